// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the LSU.
// One transaction is outstanding at a time. The LSU has fixed priority, but a
// starvation counter forces a fetch grant after MAX_STARVE back-to-back LSU
// grants that happen while fetch is waiting.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_if_req,
  input  logic [XLEN-1:0] i_if_addr,
  output logic            o_if_gnt,
  output logic            o_if_rvalid,
  output logic [XLEN-1:0] o_if_rdata,
  input  logic            i_if_flush,
  input  logic            i_ls_req,
  input  logic            i_ls_we,
  input  logic [XLEN-1:0] i_ls_addr,
  input  logic [XLEN-1:0] i_ls_wdata,
  input  logic [3:0]      i_ls_be,
  output logic            o_ls_gnt,
  output logic            o_ls_rvalid,
  output logic [XLEN-1:0] o_ls_rdata,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [3:0]      o_mem_be,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_busy
);

  localparam int CW = $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {IDLE, REQ_HOLD, WAIT_RSP} state_t;

  state_t          state_reg, state_next;
  logic            lock_reg, lock_next;     // 1 = LSU locked, 0 = fetch locked
  logic            owner_reg, owner_next;   // 1 = LSU owns the outstanding access
  logic            drop_reg, drop_next;     // fetch response must be discarded
  logic [CW-1:0]   starve_cnt_reg, starve_cnt_next;
  logic [XLEN-1:0] if_rdata_reg, ls_rdata_reg;

  logic sel_valid, sel_ls, starved, accept, rsp, if_drop, if_rsp, ls_rsp;

  assign starved = i_if_req && (starve_cnt_reg == CW'(MAX_STARVE));
  assign accept  = sel_valid && i_mem_gnt && !i_reset;
  assign rsp     = (state_reg == WAIT_RSP) && i_mem_rvalid && !i_reset;
  // A flush arriving together with the response still cancels it.
  assign if_drop = drop_reg || i_if_flush;
  assign if_rsp  = rsp && !owner_reg && !if_drop;
  assign ls_rsp  = rsp && owner_reg;

  // Pick the requester presented to memory: live priority in IDLE, the lock while holding.
  always_comb begin
    sel_valid = 1'b0;
    sel_ls    = 1'b0;
    case (state_reg)
      IDLE: begin
        sel_ls    = i_ls_req && !starved;
        sel_valid = sel_ls || i_if_req;
      end
      REQ_HOLD: begin
        sel_valid = 1'b1;
        sel_ls    = lock_reg;
      end
      default: ;
    endcase
  end

  // State register plus the bookkeeping registers that travel with it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg      <= IDLE;
      lock_reg       <= 1'b0;
      owner_reg      <= 1'b0;
      drop_reg       <= 1'b0;
      starve_cnt_reg <= '0;
      if_rdata_reg   <= '0;
      ls_rdata_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      lock_reg       <= lock_next;
      owner_reg      <= owner_next;
      drop_reg       <= drop_next;
      starve_cnt_reg <= starve_cnt_next;
      if (if_rsp) if_rdata_reg <= i_mem_rdata;
      if (ls_rsp) ls_rdata_reg <= i_mem_rdata;
    end
  end

  // Next-state, lock/owner/drop tracking and starvation counting.
  always_comb begin
    state_next      = state_reg;
    lock_next       = lock_reg;
    owner_next      = owner_reg;
    drop_next       = drop_reg;
    starve_cnt_next = starve_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (sel_valid) begin
          lock_next = sel_ls;
          drop_next = !sel_ls && i_if_flush;
          if (i_mem_gnt) begin
            owner_next = sel_ls;
            state_next = WAIT_RSP;
          end else begin
            state_next = REQ_HOLD;
          end
        end
      end
      REQ_HOLD: begin
        // A flush before acceptance cannot cancel the request, so remember it.
        drop_next = drop_reg || (!lock_reg && i_if_flush);
        if (i_mem_gnt) begin
          owner_next = lock_reg;
          state_next = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        drop_next = drop_reg || (!owner_reg && i_if_flush);
        if (i_mem_rvalid) begin
          drop_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!i_if_req) begin
      starve_cnt_next = '0;
    end else if (accept && !sel_ls) begin
      starve_cnt_next = '0;
    end else if (accept && sel_ls && (starve_cnt_reg != CW'(MAX_STARVE))) begin
      starve_cnt_next = starve_cnt_reg + CW'(1);
    end
  end

  // Outputs: memory payload mux, grants, response routing; all forced low in reset.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_be    = 4'h0;
    o_if_gnt    = 1'b0;
    o_ls_gnt    = 1'b0;
    o_if_rvalid = 1'b0;
    o_ls_rvalid = 1'b0;
    o_if_rdata  = '0;
    o_ls_rdata  = '0;
    o_busy      = 1'b0;
    if (!i_reset) begin
      o_mem_req = sel_valid;
      if (sel_valid) begin
        if (sel_ls) begin
          o_mem_we    = i_ls_we;
          o_mem_addr  = i_ls_addr;
          o_mem_wdata = i_ls_wdata;
          o_mem_be    = i_ls_be;
        end else begin
          o_mem_addr = i_if_addr;
          o_mem_be   = 4'hF;
        end
      end
      o_if_gnt    = accept && !sel_ls;
      o_ls_gnt    = accept && sel_ls;
      o_if_rvalid = if_rsp;
      o_ls_rvalid = ls_rsp;
      o_if_rdata  = if_rsp ? i_mem_rdata : if_rdata_reg;
      o_ls_rdata  = ls_rsp ? i_mem_rdata : ls_rdata_reg;
      o_busy      = (state_reg != IDLE);
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between instruction fetch (IF) and the load/store unit (LSU) of the core.
- Sequences one outstanding transaction at a time and routes each response back to its owner.
- LSU has fixed priority, with a starvation counter that guarantees fetch progress.
- Sits between the fetch stage / LSU and the unified memory model, downstream of the decode controller's dmem_we/lsu_size/lsu_signed outputs.

Parameters:
- XLEN, 32, address/data width
- MAX_STARVE, 4, consecutive LSU grants with fetch pending before fetch is forced to win (>=1)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_if_req  in  1  fetch request
- i_if_addr  in  XLEN  fetch address
- o_if_gnt  out  1  fetch request accepted
- o_if_rvalid  out  1  fetch data valid
- o_if_rdata  out  XLEN  fetch data
- i_if_flush  in  1  discard the pending fetch response (redirect)
- i_ls_req  in  1  LSU request
- i_ls_we  in  1  LSU write
- i_ls_addr  in  XLEN  LSU address
- i_ls_wdata  in  XLEN  LSU write data
- i_ls_be  in  4  LSU byte enables
- o_ls_gnt  out  1  LSU request accepted
- o_ls_rvalid  out  1  LSU response (load data or write ack)
- o_ls_rdata  out  XLEN  LSU load data
- o_mem_req  out  1  memory request
- o_mem_we  out  1  memory write
- o_mem_addr  out  XLEN  memory address
- o_mem_wdata  out  XLEN  memory write data
- o_mem_be  out  4  memory byte enables (4'hF for fetch)
- i_mem_gnt  in  1  memory accepted request
- i_mem_rvalid  in  1  memory response valid (reads and writes)
- i_mem_rdata  in  XLEN  memory read data
- o_busy  out  1  transaction outstanding

Behaviour:
- Reset (synchronous, active-high): state=IDLE, lock=0, owner=IF, starve_cnt=0.
  - All outputs 0 in the reset cycle; gnt/rvalid outputs are 0 while i_reset=1.
- Handshake rules:
  - Requesters hold req and payload stable until their gnt.
  - Memory side follows the same rule: o_mem_req and its payload stay stable until i_mem_gnt.
- FSM states: IDLE, REQ_HOLD, WAIT_RSP.
- IDLE:
  - Selection: if i_ls_req and not (i_if_req and starve_cnt==MAX_STARVE) -> LSU; else if i_if_req -> IF; else no request.
  - Drive o_mem_* combinationally from the selected requester.
  - Granted (i_mem_gnt=1): assert that requester's gnt in the same cycle, record owner, go to WAIT_RSP.
  - Not granted: latch the selection (lock) and go to REQ_HOLD.
- REQ_HOLD:
  - Keep driving the locked requester's payload and ignore the priority logic.
  - On i_mem_gnt: assert its gnt, go to WAIT_RSP.
- WAIT_RSP:
  - o_mem_req=0, o_busy=1.
  - On i_mem_rvalid: pulse the owner's rvalid for 1 cycle with rdata=i_mem_rdata, return to IDLE.
  - A new request may issue no earlier than the cycle after rvalid.
  - Minimum turnaround is 2 cycles per access (grant cycle + response cycle).
- Flush:
  - i_if_flush while owner=IF in WAIT_RSP, or in the same cycle as the IF grant, sets a drop flag.
  - The matching response is consumed and o_if_rvalid stays 0.
  - Flush has no effect on LSU transactions, or when IF is not outstanding.
  - A flush in REQ_HOLD with IF locked does not cancel the request (it has not been accepted yet); the later response is dropped.
- starve_cnt:
  - Increments (saturating at MAX_STARVE) on each LSU grant while i_if_req=1.
  - Clears on any IF grant, or in any cycle with i_if_req=0.
- i_mem_rvalid outside WAIT_RSP is ignored; no output changes.
- Reset during REQ_HOLD or WAIT_RSP abandons the transaction; no rvalid is produced afterwards.
- o_if_rdata / o_ls_rdata hold their last value when not valid; only the rvalid pulse is significant.

Test Plan:
- Single fetch, memory grants immediately and returns rvalid next cycle with 0x00500093 -> o_if_gnt in cycle 0, o_if_rvalid with that data in cycle 1, o_ls_rvalid=0.
- i_if_req and i_ls_req both high in IDLE, LSU write addr 0x100, wdata 0xDEADBEEF, be 4'b0011 -> o_mem_we=1 with that payload, o_ls_gnt=1, o_if_gnt=0; IF granted only after the LSU rvalid.
- i_mem_gnt held low 3 cycles while LSU selected; fetch request arrives mid-hold -> o_mem_addr/wdata stay the LSU values every cycle, and the LSU is granted on cycle 4.
- LSU requests continuously with MAX_STARVE=4 and fetch pending -> exactly 4 LSU grants, then the IF grant, then starve_cnt=0 and LSU wins again.
- IF granted, i_if_flush=1 the next cycle, rvalid returns 0x12345678 -> o_if_rvalid stays 0, FSM returns to IDLE, next fetch serviced normally.
- i_reset asserted in WAIT_RSP, rvalid arrives the cycle after reset deasserts -> no rvalid output, o_busy=0, all gnt=0, next request served normally.
